// File: rtl/pack_s3_stream.sv
// Ternary packer: converts LANES groups of 5 trits per beat into bytes and
// shifts them into a wide packed register, with flow control and status.
module pack_s3_stream #(
    parameter int LANES     = 2,
    parameter int OUT_BYTES = 136,
    parameter int CNT_W     = 8
) (
    input  logic                   local_clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   hold,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*10-1:0]    in_trits,
    output logic [OUT_BYTES*8-1:0] out_data,
    output logic [CNT_W-1:0]       byte_cnt,
    output logic                   done,
    output logic                   err
);

    localparam int BEATS = OUT_BYTES / LANES;
    localparam int OW    = OUT_BYTES * 8;
    localparam int SW    = LANES * 8;

    logic [CNT_W-1:0] beat_cnt_q;
    logic             s1_valid_q;
    logic [SW-1:0]    s1_bytes_q;
    logic [SW-1:0]    s1_bytes_d;
    logic [OW-1:0]    data_q;
    logic [OW-1:0]    data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             err_q;
    logic             bad_trit;
    logic             accept;

    function automatic logic [7:0] trit_val(input logic [1:0] c);
        return (c == 2'b11) ? 8'd0 : {6'd0, c};
    endfunction

    // Horner evaluation from t4 down; max 242 so 8 bits never overflow
    function automatic logic [7:0] lane_byte(input logic [9:0] g);
        logic [7:0] acc;
        acc = 8'd0;
        for (int i = 4; i >= 0; i--) begin
            acc = acc * 8'd3 + trit_val(g[2*i +: 2]);
        end
        return acc;
    endfunction

    always_comb begin
        s1_bytes_d = '0;
        bad_trit   = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            s1_bytes_d[l*8 +: 8] = lane_byte(in_trits[l*10 +: 10]);
            for (int i = 0; i < 5; i++) begin
                if (in_trits[l*10 + 2*i +: 2] == 2'b11) begin
                    bad_trit = 1'b1;
                end
            end
        end
    end

    assign in_ready = !hold && !clr && (beat_cnt_q < CNT_W'(BEATS));
    assign accept   = in_valid && in_ready;

    assign data_d = {s1_bytes_q, data_q[OW-1:SW]};
    assign cnt_d  = cnt_q + CNT_W'(LANES);

    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_bytes_q <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clr) begin
            beat_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_bytes_q <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (!hold) begin
            if (accept) begin
                s1_bytes_q <= s1_bytes_d;
                s1_valid_q <= 1'b1;
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (bad_trit) begin
                    err_q <= 1'b1;
                end
            end else begin
                s1_valid_q <= 1'b0;
            end
            if (s1_valid_q) begin
                data_q <= data_d;
                cnt_q  <= cnt_d;
                if (cnt_d == CNT_W'(OUT_BYTES)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign out_data = data_q;
    assign byte_cnt = cnt_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
